// File: rtl/mem_bus_responder_if.sv
// Signal bundle between the 8-bit multiplexed CPU bus pins, the local memory port
// and the responder. The responder uses the slave view, the initiator/memory side the master view.
interface mem_bus_responder_if;
    logic        sync;
    logic [7:0]  addr_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  data_oe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err_late;

    modport slave (
        input  sync, addr_in, data_in, mem_ready, mem_rdata,
        output data_out, data_oe, mem_addr, mem_wdata, mem_we, mem_valid, err_late
    );

    modport master (
        output sync, addr_in, data_in, mem_ready, mem_rdata,
        input  data_out, data_oe, mem_addr, mem_wdata, mem_we, mem_valid, err_late
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side end of the 10-phase, 8-bit time-multiplexed CPU bus: assembles one
// request per frame, runs the memory handshake and returns read data byte by byte.
module mem_bus_responder (
    input  logic               clk,
    input  logic               rst,
    mem_bus_responder_if.slave bus
);
    localparam logic [3:0] LAST_PH = 4'd9;

    logic [3:0]  p_q, p_d, ph;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic        rd_ok_q, rd_ok_d;
    logic        err_q, err_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  doe_q, doe_d;

    always_comb begin
        p_d     = p_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        valid_d = valid_q;
        rd_ok_d = rd_ok_q;
        err_d   = err_q;
        dout_d  = dout_q;
        doe_d   = doe_q;

        // A sync cycle behaves as phase 0, so nothing is captured during it.
        ph = bus.sync ? 4'd0 : p_q;

        if (bus.sync) begin
            p_d = 4'd1;
        end else if (p_q >= LAST_PH) begin
            p_d = 4'd0;
        end else begin
            p_d = p_q + 4'd1;
        end

        case (ph)
            4'd1: begin addr_d[7:0]   = bus.addr_in; wdata_d[7:0]   = bus.data_in; end
            4'd2: begin addr_d[15:8]  = bus.addr_in; wdata_d[15:8]  = bus.data_in; end
            4'd3: begin addr_d[23:16] = bus.addr_in; wdata_d[23:16] = bus.data_in; end
            4'd4: begin addr_d[31:24] = bus.addr_in; wdata_d[31:24] = bus.data_in; end
            4'd5: begin we_d = bus.addr_in[0]; valid_d = 1'b1; end
            default: ;
        endcase

        if (valid_q && !bus.sync) begin
            if (bus.mem_ready) begin
                valid_d = 1'b0;
                if (!we_q) begin
                    if (ph == 4'd6) begin
                        rdata_d = bus.mem_rdata;
                        rd_ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else if (ph == LAST_PH) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
        end

        // Lane drive: byte n is loaded at the edge ending phase 6+n, the lane is released after phase 0.
        case (ph)
            4'd0: begin
                rd_ok_d = 1'b0;
                doe_d   = 8'h00;
                dout_d  = 8'h00;
            end
            4'd6: if (rd_ok_d) begin doe_d = 8'hFF; dout_d = bus.mem_rdata[7:0]; end
            4'd7: if (rd_ok_q) begin doe_d = 8'hFF; dout_d = rdata_q[15:8];      end
            4'd8: if (rd_ok_q) begin doe_d = 8'hFF; dout_d = rdata_q[23:16];     end
            4'd9: if (rd_ok_q) begin doe_d = 8'hFF; dout_d = rdata_q[31:24];     end
            default: ;
        endcase

        if (bus.sync) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 8'h00;
            doe_q   <= 8'h00;
        end else begin
            p_q     <= p_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
        end
    end

    // Read data is only consumed while rd_ok is set, so it needs no reset.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_valid = valid_q;
    assign bus.err_late  = err_q;
    assign bus.data_out  = dout_q;
    assign bus.data_oe   = doe_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Frame-level bench for mem_bus_responder: each frame is a transaction descriptor
// from which the expected bus and memory-port waveform is derived phase by phase.
module tb_mem_bus_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_bus_responder_if bus ();

    mem_bus_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // rp: phase of mem_ready (10 = never); sp: phase at which sync is raised (-1 = never)
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        we;
        int          rp;
        int          sp;
    } frame_t;

    int n_chk = 0;
    int n_err = 0;
    int fidx  = 0;

    logic [31:0] prv_addr, prv_wdata, prv_rdata;
    logic        prv_we, prv_rd_ok;
    logic        err_m;
    int          start_ph;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] o, input logic [31:0] n, input int nb);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (i < nb) r[8*i +: 8] = n[8*i +: 8];
        end
        return r;
    endfunction

    // Bytes already captured when phase p is under way.
    function automatic int nbytes(input int p);
        if (p <= 1) return 0;
        if (p >= 5) return 4;
        return p - 1;
    endfunction

    function automatic frame_t mk(input logic [31:0] a, input logic [31:0] w, input logic [31:0] r,
                                  input logic we, input int rp, input int sp);
        frame_t f;
        f.addr = a; f.wdata = w; f.rdata = r; f.we = we; f.rp = rp; f.sp = sp;
        return f;
    endfunction

    function automatic frame_t rnd_frame(input bit safe);
        frame_t f;
        f.addr  = $urandom;
        f.wdata = $urandom;
        f.rdata = $urandom;
        f.we    = 1'($urandom_range(0, 1));
        if (safe) f.rp = f.we ? $urandom_range(6, 9) : 6;
        else      f.rp = $urandom_range(6, 10);
        f.sp = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 9) : -1;
        return f;
    endfunction

    task automatic model_reset();
        prv_addr  = 32'h0;
        prv_wdata = 32'h0;
        prv_rdata = 32'h0;
        prv_we    = 1'b0;
        prv_rd_ok = 1'b0;
        err_m     = 1'b0;
        start_ph  = 0;
    endtask

    task automatic drive_garbage();
        bus.sync      = 1'($urandom_range(0, 1));
        bus.addr_in   = 8'($urandom);
        bus.data_in   = 8'($urandom);
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_garbage();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst data_oe",   32'(bus.data_oe),   32'h0);
        chk("rst data_out",  32'(bus.data_out),  32'h0);
        chk("rst mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst err_late",  32'(bus.err_late),  32'h0);
        chk("rst mem_addr",  bus.mem_addr,       32'h0);
        chk("rst mem_wdata", bus.mem_wdata,      32'h0);
        chk("rst mem_we",    32'(bus.mem_we),    32'h0);
    endtask

    task automatic run_frame(input frame_t f);
        bit   trunc, rd_ok, ev, ee;
        int   last, late_ph, lim, nb;
        logic [7:0] eoe, eout;
        string pre;

        trunc   = (f.sp >= 1);
        last    = trunc ? f.sp : 9;
        rd_ok   = !f.we && (f.rp == 6);
        late_ph = (f.rp == 10) ? 9 : ((!f.we && f.rp >= 7) ? f.rp : 99);
        lim     = (f.rp > 9) ? 9 : f.rp;

        for (int p = start_ph; p <= last; p++) begin
            pre = $sformatf("f%0d p%0d", fidx, p);
            ev  = (p >= 6) && (p <= lim);
            ee  = err_m || (late_ph < p);
            eoe  = 8'h00;
            eout = 8'h00;
            if (p == 0 && prv_rd_ok) begin eoe = 8'hFF; eout = prv_rdata[31:24]; end
            if (p >= 7 && rd_ok)      begin eoe = 8'hFF; eout = f.rdata[8*(p-7) +: 8]; end

            chk({pre, " mem_valid"}, 32'(bus.mem_valid), 32'(ev));
            chk({pre, " data_oe"},   32'(bus.data_oe),   32'(eoe));
            chk({pre, " data_out"},  32'(bus.data_out),  32'(eout));
            chk({pre, " err_late"},  32'(bus.err_late),  32'(ee));
            chk({pre, " mem_we"},    32'(bus.mem_we),    32'((p >= 6) ? f.we : prv_we));
            chk({pre, " mem_addr"},  bus.mem_addr,       mix(prv_addr,  f.addr,  nbytes(p)));
            chk({pre, " mem_wdata"}, bus.mem_wdata,      mix(prv_wdata, f.wdata, nbytes(p)));

            bus.sync = (p == f.sp);
            if (p >= 1 && p <= 4) begin
                bus.addr_in = f.addr[8*(p-1) +: 8];
                bus.data_in = f.wdata[8*(p-1) +: 8];
            end else begin
                bus.addr_in = (p == 5) ? {7'($urandom), f.we} : 8'($urandom);
                bus.data_in = 8'($urandom);
            end
            bus.mem_ready = (p == f.rp) || (((p < 6) || (p > f.rp)) && ($urandom_range(0, 3) == 0));
            bus.mem_rdata = (p == f.rp) ? f.rdata : $urandom;

            @(posedge clk);
            #1;
        end
        bus.sync = 1'b0;

        if (late_ph < (trunc ? f.sp : 10)) err_m = 1'b1;
        nb        = trunc ? nbytes(f.sp) : 4;
        prv_addr  = mix(prv_addr,  f.addr,  nb);
        prv_wdata = mix(prv_wdata, f.wdata, nb);
        if (!trunc || f.sp >= 6) prv_we = f.we;
        prv_rd_ok = rd_ok && !trunc;
        prv_rdata = f.rdata;
        start_ph  = trunc ? 1 : 0;
        fidx++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.sync      = 1'b0;
        bus.addr_in   = 8'h00;
        bus.data_in   = 8'h00;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        model_reset();

        do_reset();

        // Error-free traffic: err_late must stay low throughout.
        run_frame(mk(32'h12345678, 32'hAABBCCDD, $urandom, 1'b1, 7, -1));
        run_frame(mk(32'h00000010, $urandom, 32'hCAFEF00D, 1'b0, 6, -1));
        for (int i = 0; i < 15; i++) run_frame(rnd_frame(1'b1));
        run_frame(mk($urandom, $urandom, 32'h89ABCDEF, 1'b0, 6, 7));
        run_frame(mk($urandom, $urandom, $urandom, 1'b1, 6, -1));
        run_frame(mk($urandom, $urandom, $urandom, 1'b1, 10, 8));
        for (int i = 0; i < 15; i++) run_frame(rnd_frame(1'b1));

        // Deadline misses, then unrestricted traffic.
        run_frame(mk($urandom, $urandom, $urandom, 1'b0, 8, -1));
        run_frame(mk($urandom, $urandom, $urandom, 1'b1, 10, -1));
        run_frame(mk($urandom, $urandom, $urandom, 1'b0, 6, -1));
        for (int i = 0; i < 25; i++) run_frame(rnd_frame(1'b0));

        // Reset from an arbitrary point mid-frame must clear the sticky error.
        repeat ($urandom_range(1, 9)) begin
            drive_garbage();
            @(posedge clk);
            #1;
        end
        do_reset();
        for (int i = 0; i < 5; i++) run_frame(rnd_frame(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side end of the 8-bit time-multiplexed CPU bus. It tracks the 10-phase bus frame and assembles the 32-bit address, write data and read/write flag from the byte lanes. It issues one request per frame to a local memory port. For read frames it drives the 32-bit read data back onto the shared data lane, one byte per phase. It sits between the package pins carrying the initiator's frame and an on-chip or off-chip memory/peripheral.

## Interface
Parameters:
- None. Frame length (10), bus width (8) and word width (32) are fixed.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- sync  in  1  frame realign: current cycle is treated as phase 0
- addr_in  in  8  address/control byte lane from initiator
- data_in  in  8  write-data byte lane from initiator
- data_out  out  8  read-data byte lane to initiator
- data_oe  out  8  lane drive enable (0xFF drive, 0x00 release)
- mem_addr  out  32  request address
- mem_wdata  out  32  request write data
- mem_we  out  1  1=write, 0=read; valid while mem_valid
- mem_valid  out  1  request pending
- mem_ready  in  1  memory accepts/completes request (rdata valid same cycle for reads)
- mem_rdata  in  32  read data
- err_late  out  1  sticky: a memory response missed its deadline

## Operation
- Phase counter p (4 bits): runs 0..9 and wraps 9->0 every clk.
  - If sync=1, p becomes 1 next cycle.
  - sync overrides wrap.
- Capture at the rising edge ending each phase:
  - p=1..4: addr byte p-1 <= addr_in and wdata byte p-1 <= data_in. Byte 0 is the LSB, so ordering is little-endian.
  - p=5: mem_we <= addr_in[0] and mem_valid <= 1. mem_addr and mem_wdata hold the assembled words, stable for the whole request.
- Request handshake:
  - mem_valid holds until mem_ready=1 is sampled; it clears at that edge.
  - Late request: if it is still pending at the edge ending p=9, mem_valid <= 0 (abort) and err_late <= 1.
- Read deadline:
  - A read must see mem_ready during p=6. At that edge mem_rdata is latched, rd_ok <= 1 and data_out <= mem_rdata[7:0].
  - A read completing at p=7..9 is late: err_late <= 1, data discarded, rd_ok stays 0.
- Write deadline: a write may complete any time in p=6..9.
- Read drive (rd_ok=1):
  - Edges ending p=6,7,8,9 set data_oe <= 0xFF.
  - data_out gets bytes 0,1,2,3 respectively, so the bytes are visible during p=7,8,9,0.
  - The edge ending p=0 sets data_oe <= 0x00 and rd_ok <= 0.
  - For write frames, failed reads, or rd_ok=0, data_oe stays 0x00 and data_out holds 0x00.
- sync during a frame:
  - Drops mem_valid and rd_ok at that edge.
  - Sets data_oe <= 0x00 and data_out <= 0x00.
  - Does not set err_late.
  - Captured bytes are overwritten by the new frame.
- Simultaneous events:
  - mem_ready in the same cycle as the p=9 abort counts as completion, with no error.
  - mem_ready while mem_valid=0 is ignored.

## Timing
- Reset values (edge with rst=1): p=0; data_out=0x00; data_oe=0x00; mem_addr=0; mem_wdata=0; mem_we=0; mem_valid=0; rd_ok=0; err_late=0. rst overrides sync.
- All outputs are registered; there is no combinational path from inputs to outputs.
- mem_valid rises in p=6, one cycle after the rw byte.
- Zero-wait read: mem_ready in p=6, byte0 on the lane in p=7, byte3 in p=0 of the next frame.
- A new frame's p=5 request cannot overlap the previous one, because every request terminates by the end of p=9.
- err_late clears only on rst.

## Test plan
- Reset: hold rst 2 cycles, release -> p=0, data_oe=0x00, mem_valid=0, err_late=0; first request appears exactly 6 cycles after release.
- Write frame:
  - Stimulus: addr_in 0x78,0x56,0x34,0x12 and data_in 0xDD,0xCC,0xBB,0xAA in p=1..4; addr_in=0x01 in p=5; mem_ready in p=7.
  - Required: mem_addr=0x12345678, mem_wdata=0xAABBCCDD, mem_we=1, mem_valid high p=6..7, data_oe never set.
- Zero-wait read:
  - Stimulus: address 0x00000010, rw byte 0x00, mem_ready in p=6 with rdata 0xCAFEF00D.
  - Required: data_out 0x0D,0xF0,0xFE,0xCA during p=7,8,9,0; data_oe=0xFF only in those phases.
- Late read, mem_ready in p=8 -> err_late=1, data_oe stays 0x00, mem_valid clears after p=8.
- No response to write -> mem_valid clears at end of p=9, err_late=1, next frame issues normally.
- sync at p=7 of a read frame -> data_oe=0x00 next cycle, p=1, err_late unchanged; following frame operates normally.
